// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one sqrt_fixed core between NUM_REQ requesters.
// Define SQRT_ARB_TIMEOUT_EN to add a WAIT-state watchdog and the timeout_err output.
module sqrt_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int IDX_WIDTH = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*IN_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [OUT_WIDTH-1:0]         result,
    output logic                         busy,
    output logic                         sqrt_input_ready,
    output logic [IN_WIDTH-1:0]          sqrt_in,
    input  logic                         sqrt_flag_new_input,
    input  logic                         sqrt_output_ready,
    input  logic                         sqrt_in_use,
    input  logic [OUT_WIDTH-1:0]         sqrt_out
`ifdef SQRT_ARB_TIMEOUT_EN
    ,
    output logic                         timeout_err
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDX_WIDTH) < NUM_REQ ||
        TIMEOUT < 1 || TIMEOUT > 255) begin : gBadParams
        $error("sqrt_arbiter: illegal parameter combination");
    end

    state_t                 state_q;
    logic [NUM_REQ-1:0]     gnt_q;
    logic [NUM_REQ-1:0]     done_q;
    logic [OUT_WIDTH-1:0]   result_q;
    logic                   busy_q;
    logic                   inReady_q;
    logic [IN_WIDTH-1:0]    sqrtIn_q;
    logic [IDX_WIDTH-1:0]   rrPtr_q;
    logic [IDX_WIDTH-1:0]   owner_q;

    logic                   grantValid_d;
    logic [IDX_WIDTH-1:0]   grantIdx_d;

    logic [IN_WIDTH-1:0]    reqOperand [NUM_REQ];

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam logic [7:0] WdLimit = 8'(TIMEOUT);
    logic [7:0]             wdCnt_q;
    logic                   timeoutErr_q;
    assign timeout_err = timeoutErr_q;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : gUnpack
        assign reqOperand[g] = req_data[g*IN_WIDTH +: IN_WIDTH];
    end

    // Scan downward so the candidate closest to the pointer is the last one written and wins.
    always_comb begin : pickBlk
        int c;
        logic [IDX_WIDTH-1:0] cIdx;
        grantValid_d = 1'b0;
        grantIdx_d   = '0;
        c            = 0;
        cIdx         = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            c = int'(rrPtr_q) + i;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            cIdx = IDX_WIDTH'(c);
            if (req[cIdx]) begin
                grantValid_d = 1'b1;
                grantIdx_d   = cIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            inReady_q <= 1'b0;
            sqrtIn_q  <= '0;
            rrPtr_q   <= '0;
            owner_q   <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
            wdCnt_q      <= '0;
            timeoutErr_q <= 1'b0;
`endif
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
            timeoutErr_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (grantValid_d && !sqrt_in_use) begin
                        sqrtIn_q  <= reqOperand[grantIdx_d];
                        owner_q   <= grantIdx_d;
                        gnt_q     <= NUM_REQ'(1) << grantIdx_d;
                        inReady_q <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                // A refused handshake drops input_ready and retries once the core frees up.
                ISSUE: begin
                    if (inReady_q) begin
                        inReady_q <= 1'b0;
                        if (sqrt_flag_new_input) begin
                            busy_q  <= 1'b1;
                            state_q <= WAIT;
`ifdef SQRT_ARB_TIMEOUT_EN
                            wdCnt_q <= '0;
`endif
                        end
                    end else if (!sqrt_in_use) begin
                        inReady_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (sqrt_output_ready) begin
                        result_q <= sqrt_out;
                        done_q   <= NUM_REQ'(1) << owner_q;
                        busy_q   <= 1'b0;
                        state_q  <= DELIVER;
                    end
`ifdef SQRT_ARB_TIMEOUT_EN
                    else if (wdCnt_q == WdLimit) begin
                        result_q     <= '1;
                        done_q       <= NUM_REQ'(1) << owner_q;
                        busy_q       <= 1'b0;
                        timeoutErr_q <= 1'b1;
                        state_q      <= DELIVER;
                    end else begin
                        wdCnt_q <= wdCnt_q + 8'd1;
                    end
`endif
                end
                DELIVER: begin
                    rrPtr_q <= (owner_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt              = gnt_q;
    assign done             = done_q;
    assign result           = result_q;
    assign busy             = busy_q;
    assign sqrt_input_ready = inReady_q;
    assign sqrt_in          = sqrtIn_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a 20-cycle floor(sqrt) core stub.
// Define SQRT_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_sqrt_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int IN_WIDTH  = 32;
    localparam int OUT_WIDTH = 16;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*IN_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          done;
    logic [OUT_WIDTH-1:0]        result;
    logic                        busy;
    logic                        sqrt_input_ready;
    logic [IN_WIDTH-1:0]         sqrt_in;
    logic                        sqrt_flag_new_input;
    logic                        sqrt_output_ready;
    logic                        sqrt_in_use;
    logic [OUT_WIDTH-1:0]        sqrt_out;
`ifdef SQRT_ARB_TIMEOUT_EN
    logic                        timeout_err;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;
    int doneCount   = 0;
    int gntCount    = 0;
    bit doneMulti   = 1'b0;

    logic        extraBusy = 1'b0;
    logic        stubMute  = 1'b0;
    logic [4:0]  stubCnt;
    logic [15:0] stubOut;

    sqrt_arbiter dut (
        .clk                 (clk),
        .reset               (reset),
        .req                 (req),
        .req_data            (req_data),
        .gnt                 (gnt),
        .done                (done),
        .result              (result),
        .busy                (busy),
        .sqrt_input_ready    (sqrt_input_ready),
        .sqrt_in             (sqrt_in),
        .sqrt_flag_new_input (sqrt_flag_new_input),
        .sqrt_output_ready   (sqrt_output_ready),
        .sqrt_in_use         (sqrt_in_use),
        .sqrt_out            (sqrt_out)
`ifdef SQRT_ARB_TIMEOUT_EN
        ,
        .timeout_err         (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if (32'(t) * 32'(t) <= x) r = t;
        end
        return r;
    endfunction

    // Core stub: accepts when idle, busy for 21 cycles, result on the last of them.
    assign sqrt_in_use         = (stubCnt != 5'd0) || extraBusy;
    assign sqrt_flag_new_input = sqrt_input_ready && !sqrt_in_use;
    assign sqrt_output_ready   = (stubCnt == 5'd1) && !stubMute;
    assign sqrt_out            = stubOut;

    always @(posedge clk) begin
        if (reset) begin
            stubCnt <= '0;
            stubOut <= '0;
        end else if (sqrt_flag_new_input) begin
            stubCnt <= 5'd21;
            stubOut <= isqrt(sqrt_in);
        end else if (stubCnt != 5'd0) begin
            stubCnt <= stubCnt - 5'd1;
        end
    end

    always @(negedge clk) begin
        if ($countones(done) > 1) doneMulti = 1'b1;
        if (done != '0) doneCount++;
        if (gnt != '0) gntCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [31:0] operand);
        req_data[idx*IN_WIDTH +: IN_WIDTH] = operand;
        req[idx] = 1'b1;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic waitGnt(input string tag, output int gCyc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == '0 && n < 200);
        if (gnt == '0) checkOutput({tag, "GntTimeout"}, 32'(gnt), 32'h1);
        gCyc = cyc;
    endtask

    task automatic waitDone(input string tag, input int budget, output int dCyc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (done == '0 && n < budget);
        if (done == '0) checkOutput({tag, "DoneTimeout"}, 32'(done), 32'h1);
        dCyc = cyc;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: simulation still running, expected completion");
        $fatal(1, "[TB] global time limit reached");
    end

    initial begin
        int g, d, gMark, dMark;
        int allOps [4]    = '{1, 4, 9, 16};
        int allRes [4]    = '{1, 2, 3, 4};
        int fairGnt [3]   = '{4, 8, 1};
        int fairRes [3]   = '{6, 7, 8};

        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        tick();
        tick();
        checkOutput("rstGnt",     32'(gnt), 0);
        checkOutput("rstDone",    32'(done), 0);
        checkOutput("rstResult",  32'(result), 0);
        checkOutput("rstBusy",    32'(busy), 0);
        checkOutput("rstInReady", 32'(sqrt_input_ready), 0);
        checkOutput("rstSqrtIn",  sqrt_in, 0);
        reset = 1'b0;
        tick();

        applyStimulus(0, 32'd144);
        waitGnt("single", g);
        checkOutput("singleGnt", 32'(gnt), 32'h1);
        checkOutput("singleSqrtIn", sqrt_in, 32'd144);
        checkOutput("singleInReady", 32'(sqrt_input_ready), 1);
        req[0] = 1'b0;
        tick();
        checkOutput("singleBusy", 32'(busy), 1);
        waitDone("single", 60, d);
        checkOutput("singleLatency", 32'(d - g), 32'd22);
        checkOutput("singleDone", 32'(done), 32'h1);
        checkOutput("singleResult", 32'(result), 32'd12);
        checkOutput("singleBusyAtDone", 32'(busy), 0);
        tick();
        checkOutput("singleDoneDrop", 32'(done), 0);
        checkOutput("singleBusyAfter", 32'(busy), 0);

        pulseReset();
        for (int i = 0; i < 4; i++) applyStimulus(i, 32'(allOps[i]));
        for (int k = 0; k < 4; k++) begin
            waitGnt($sformatf("all%0d", k), g);
            checkOutput($sformatf("allGnt%0d", k), 32'(gnt), 32'(1 << k));
            req[k] = 1'b0;
            waitDone($sformatf("all%0d", k), 60, d);
            checkOutput($sformatf("allDone%0d", k), 32'(done), 32'(1 << k));
            checkOutput($sformatf("allResult%0d", k), 32'(result), 32'(allRes[k]));
        end
        checkOutput("doneOneHot", 32'(doneMulti), 0);

        pulseReset();
        applyStimulus(0, 32'd25);
        applyStimulus(2, 32'd36);
        applyStimulus(3, 32'd49);
        waitGnt("fairFirst", g);
        checkOutput("fairGntFirst", 32'(gnt), 32'h1);
        req[0] = 1'b0;
        waitDone("fairFirst", 60, d);
        checkOutput("fairResultFirst", 32'(result), 32'd5);
        applyStimulus(0, 32'd64);
        for (int k = 0; k < 3; k++) begin
            waitGnt($sformatf("fair%0d", k), g);
            checkOutput($sformatf("fairGnt%0d", k), 32'(gnt), 32'(fairGnt[k]));
            req = req & ~gnt;
            waitDone($sformatf("fair%0d", k), 60, d);
            checkOutput($sformatf("fairResult%0d", k), 32'(result), 32'(fairRes[k]));
        end

        applyStimulus(1, 32'd100);
        waitGnt("hold", g);
        gMark = gntCount;
        checkOutput("holdGnt", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        extraBusy = 1'b1;
        repeat (5) tick();
        extraBusy = 1'b0;
        checkOutput("holdBusy", 32'(busy), 0);
        checkOutput("holdInReady", 32'(sqrt_input_ready), 0);
        waitDone("hold", 80, d);
        checkOutput("holdLatency", 32'(d - g), 32'd28);
        checkOutput("holdResult", 32'(result), 32'd10);
        checkOutput("holdGntCount", 32'(gntCount - gMark), 32'd1);

        applyStimulus(2, 32'd400);
        waitGnt("abort", g);
        req[2] = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        checkOutput("abortGnt",     32'(gnt), 0);
        checkOutput("abortDone",    32'(done), 0);
        checkOutput("abortResult",  32'(result), 0);
        checkOutput("abortBusy",    32'(busy), 0);
        checkOutput("abortInReady", 32'(sqrt_input_ready), 0);
        checkOutput("abortSqrtIn",  sqrt_in, 0);
        reset = 1'b0;
        dMark = doneCount;
        repeat (30) tick();
        checkOutput("abortNoDone", 32'(doneCount - dMark), 0);
        applyStimulus(0, 32'hFFFF_FFFF);
        waitGnt("maxOp", g);
        checkOutput("maxOpGnt", 32'(gnt), 32'h1);
        req[0] = 1'b0;
        waitDone("maxOp", 60, d);
        checkOutput("maxOpDone", 32'(done), 32'h1);
        checkOutput("maxOpResult", 32'(result), 32'd65535);

`ifdef SQRT_ARB_TIMEOUT_EN
        tick();
        stubMute = 1'b1;
        applyStimulus(3, 32'd81);
        waitGnt("wd", g);
        checkOutput("wdGnt", 32'(gnt), 32'h8);
        req[3] = 1'b0;
        waitDone("wd", 400, d);
        checkOutput("wdLatency", 32'(d - g), 32'd257);
        checkOutput("wdDone", 32'(done), 32'h8);
        checkOutput("wdResult", 32'(result), 32'hFFFF);
        checkOutput("wdErr", 32'(timeout_err), 1);
        tick();
        checkOutput("wdErrDrop", 32'(timeout_err), 0);
        stubMute = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
